// File: rtl/seq_shift_unit.sv
// seq_shift_unit: multicycle shift engine.
// Captures a word, a shift amount and an operation on a start pulse.
// It then shifts one position per clock and reports the result with a one-cycle done strobe.
// Optional macro SHIFT_UNIT_STEP4_EN: moves four positions per clock while at least four remain.
module seq_shift_unit #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  localparam logic [AMT_W-1:0] CNT_ONE  = AMT_W'(1);
  localparam logic [AMT_W-1:0] CNT_FOUR = AMT_W'(4);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  int unsigned      step_n;
  logic [AMT_W-1:0] step_cnt;

  // Moves the work word by n positions using the fill or wrap rule of the operation.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] w,
                                                  input logic [2:0]       o,
                                                  input int unsigned      n);
    logic [WIDTH-1:0] r;
    case (o)
      OP_SLL:  r = w << n;
      OP_SRL:  r = w >> n;
      OP_SRA:  r = WIDTH'($signed(w) >>> n);
      OP_ROL:  r = (w << n) | (w >> (WIDTH - n));
      OP_ROR:  r = (w >> n) | (w << (WIDTH - n));
      default: r = w;
    endcase
    return r;
  endfunction

  // Next-state logic: capture in IDLE, step in SHIFT, publish the result in FINISH.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    count_d    = count_q;
    op_d       = op_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    data_out_d = data_out_q;
    step_n     = 1;
    step_cnt   = CNT_ONE;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d = data_in;
          op_d   = op;
          busy_d = 1'b1;
          if (op > OP_ROR) begin
            count_d = '0;
            state_d = FINISH;
          end else begin
            count_d = shamt;
            state_d = (shamt == '0) ? FINISH : SHIFT;
          end
        end
      end
      SHIFT: begin
`ifdef SHIFT_UNIT_STEP4_EN
        if (count_q >= CNT_FOUR) begin
          step_n   = 4;
          step_cnt = CNT_FOUR;
        end
`endif
        work_d  = shift_step(work_q, op_q, step_n);
        count_d = count_q - step_cnt;
        if (count_q == step_cnt) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        data_out_d = work_q;
        done_d     = 1'b1;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      count_q    <= '0;
      op_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      count_q    <= count_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      data_out_q <= data_out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign data_out = data_out_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Testbench for seq_shift_unit with a one-shot arithmetic reference model.
module tb_seq_shift_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int checks;
  int fails;

  seq_shift_unit #(.WIDTH(32), .AMT_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result: the whole shift is applied in one step.
  function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] d,
                                               input logic [4:0] s);
    logic [63:0] dd;
    logic [31:0] r;
    dd = {d, d};
    case (o)
      3'd0: r = d << s;
      3'd1: r = d >> s;
      3'd2: r = 32'($signed(d) >>> s);
      3'd3: begin dd = dd << s; r = dd[63:32]; end
      3'd4: begin dd = dd >> s; r = dd[31:0]; end
      default: r = d;
    endcase
    return r;
  endfunction

  // Reference latency in cycles from the start edge to the done cycle.
  function automatic int model_latency(input logic [2:0] o, input logic [4:0] s);
    int eff;
    eff = (o > 3'd4) ? 0 : int'(s);
`ifdef SHIFT_UNIT_STEP4_EN
    return eff / 4 + eff % 4 + 1;
`else
    return eff + 1;
`endif
  endfunction

  // Drives a start pulse at the current falling edge; returns one cycle after the start edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] d, input logic [4:0] s);
    op      = o;
    data_in = d;
    shamt   = s;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    op      = 3'($urandom_range(0, 7));
    data_in = $urandom;
    shamt   = 5'($urandom);
  endtask

  // Waits (bounded) for done; optionally pulses start with junk inputs in cycle poke_at.
  task automatic wait_done(input int poke_at, output int lat, output logic [31:0] res,
                           output bit busy_ok, output bit held_ok);
    logic [31:0] prev;
    prev    = data_out;
    lat     = 0;
    busy_ok = 1'b1;
    held_ok = 1'b1;
    while (lat < 200) begin
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (data_out !== prev) held_ok = 1'b0;
      if (lat == poke_at) begin
        start   = 1'b1;
        op      = 3'($urandom_range(0, 7));
        data_in = $urandom;
        shamt   = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    if (busy !== 1'b0) busy_ok = 1'b0;
    res = data_out;
  endtask

  // Reset values while held and after release with no start.
  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    op = '0; data_in = '0; shamt = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, data_out} !== 34'd0) begin
      fails++;
      $display("[TB] FAIL reset_hold: busy=%b done=%b data_out=%h required 0 0 00000000", busy, done, data_out);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, data_out} !== 34'd0) begin
      fails++;
      $display("[TB] FAIL reset_release: busy=%b done=%b data_out=%h required 0 0 00000000", busy, done, data_out);
    end
  endtask

  // Directed vectors from the test plan, plus the single-cycle done strobe.
  task automatic test_directed();
    logic [2:0]  ops[6]  = '{3'd0, 3'd2, 3'd4, 3'd3, 3'd1, 3'd7};
    logic [31:0] dins[6] = '{32'h1, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    logic [4:0]  shs[6]  = '{5'd4, 5'd31, 5'd1, 5'd1, 5'd0, 5'd9};
    logic [31:0] exps[6] = '{32'h10, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
`ifdef SHIFT_UNIT_STEP4_EN
    int          lats[6] = '{2, 11, 2, 2, 1, 1};
`else
    int          lats[6] = '{5, 32, 2, 2, 1, 1};
`endif
    int          lat;
    logic [31:0] res;
    bit          busy_ok, held_ok;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue(ops[i], dins[i], shs[i]);
      wait_done(-1, lat, res, busy_ok, held_ok);
      checks++;
      if (res !== exps[i]) begin
        fails++;
        $display("[TB] FAIL directed_data[%0d]: got %h required %h", i, res, exps[i]);
      end
      checks++;
      if (lat != lats[i]) begin
        fails++;
        $display("[TB] FAIL directed_latency[%0d]: got %0d required %0d", i, lat, lats[i]);
      end
      checks++;
      if (!busy_ok || !held_ok) begin
        fails++;
        $display("[TB] FAIL directed_busy_hold[%0d]: busy_ok=%0d held_ok=%0d required 1 1", i, busy_ok, held_ok);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || data_out !== exps[i]) begin
        fails++;
        $display("[TB] FAIL directed_strobe[%0d]: done=%b data_out=%h required 0 %h", i, done, data_out, exps[i]);
      end
    end
  endtask

  // Random operations checked against the reference model.
  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] d;
    logic [4:0]  s;
    int          lat;
    logic [31:0] res;
    bit          busy_ok, held_ok;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      d = $urandom;
      s = 5'($urandom);
      @(negedge clk);
      issue(o, d, s);
      wait_done(-1, lat, res, busy_ok, held_ok);
      checks++;
      if (res !== model_result(o, d, s) || lat != model_latency(o, s) || !busy_ok || !held_ok) begin
        fails++;
        $display("[TB] FAIL random[%0d] op=%0d d=%h s=%0d: got %h lat %0d busy_ok %0d held_ok %0d required %h lat %0d",
                 i, o, d, s, res, lat, busy_ok, held_ok, model_result(o, d, s), model_latency(o, s));
      end
    end
  endtask

  // Start pulses during SHIFT and during FINISH must be ignored.
  task automatic test_busy_start();
    logic [31:0] d;
    int          lat;
    logic [31:0] res;
    bit          busy_ok, held_ok;
    int          pokes[2];
    d = $urandom;
    pokes[0] = 1;
    pokes[1] = model_latency(3'd3, 5'd13) - 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      issue(3'd3, d, 5'd13);
      wait_done(pokes[i], lat, res, busy_ok, held_ok);
      checks++;
      if (res !== model_result(3'd3, d, 5'd13) || lat != model_latency(3'd3, 5'd13)) begin
        fails++;
        $display("[TB] FAIL busy_start[%0d]: got %h lat %0d required %h lat %0d",
                 i, res, lat, model_result(3'd3, d, 5'd13), model_latency(3'd3, 5'd13));
      end
      repeat (40) begin
        @(negedge clk);
        if (done === 1'b1) break;
      end
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL busy_start_queued[%0d]: done=%b busy=%b required 0 0", i, done, busy);
      end
    end
  endtask

  // A start raised in the done cycle is accepted on the following edge.
  task automatic test_back_to_back();
    logic [31:0] d0, d1;
    int          lat;
    logic [31:0] res;
    bit          busy_ok, held_ok;
    d0 = $urandom;
    d1 = $urandom;
    @(negedge clk);
    issue(3'd1, d0, 5'd6);
    wait_done(-1, lat, res, busy_ok, held_ok);
    issue(3'd2, d1, 5'd9);
    wait_done(-1, lat, res, busy_ok, held_ok);
    checks++;
    if (res !== model_result(3'd2, d1, 5'd9) || lat != model_latency(3'd2, 5'd9) || !busy_ok) begin
      fails++;
      $display("[TB] FAIL back_to_back: got %h lat %0d busy_ok %0d required %h lat %0d",
               res, lat, busy_ok, model_result(3'd2, d1, 5'd9), model_latency(3'd2, 5'd9));
    end
  endtask

  // Reset in the middle of a shift clears outputs at once and suppresses done.
  task automatic test_reset_midshift();
    int          lat;
    logic [31:0] res;
    bit          busy_ok, held_ok;
    bit          saw_done;
    @(negedge clk);
    issue(3'd4, 32'h1, 5'd1);
    wait_done(-1, lat, res, busy_ok, held_ok);
    @(negedge clk);
    issue(3'd0, 32'hFFFF_FFFF, 5'd20);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({busy, done, data_out} !== 34'd0) begin
      fails++;
      $display("[TB] FAIL reset_midshift: busy=%b done=%b data_out=%h required 0 0 00000000", busy, done, data_out);
    end
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done || busy !== 1'b0 || data_out !== 32'd0) begin
      fails++;
      $display("[TB] FAIL reset_midshift_after: saw_done=%0d busy=%b data_out=%h required 0 0 00000000",
               saw_done, busy, data_out);
    end
  endtask

  // Runs every scenario in order and prints the summary.
  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_directed();
    test_random();
    test_busy_start();
    test_back_to_back();
    test_reset_midshift();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
